// File: rtl/decoder_rr_sched.sv
// Round-robin owner scheduler driving a 6-to-64 decoder (index + enable).
// Ports: clk, rst (async high), sched_en, req[63:0], release_req -> decoder_en,
//   decoder_sel[5:0], grant_valid, timeout_pulse; with DECODER_RR_SCHED_ONEHOT_EN
//   defined, also grant_onehot[63:0] (registered one-hot of the current grant).
module decoder_rr_sched #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sched_en,
  input  logic [63:0] req,
  input  logic        release_req,
  output logic        decoder_en,
  output logic [5:0]  decoder_sel,
  output logic        grant_valid,
  output logic        timeout_pulse
`ifdef DECODER_RR_SCHED_ONEHOT_EN
  ,
  output logic [63:0] grant_onehot
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  localparam bit         TO_EN     = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t      state;
  logic [5:0]  ptr;
  logic [7:0]  cnt;

  logic        win_valid;
  logic [5:0]  win_idx;
  logic [5:0]  idx;
  logic        arb_go;
  logic        drop;
  logic        timeout;
  logic        other_exit;
  logic        leave;

  // Scan offsets high to low so the last hit is the one nearest the pointer.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    idx       = '0;
    for (int i = 63; i >= 0; i--) begin
      idx = ptr + 6'(i);
      if (req[idx]) begin
        win_valid = 1'b1;
        win_idx   = idx;
      end
    end
  end

  assign arb_go     = sched_en & win_valid;
  assign drop       = ~req[decoder_sel];
  assign timeout    = TO_EN && (cnt == HOLD_LAST);
  assign other_exit = release_req | drop | ~sched_en;
  assign leave      = other_exit | timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      cnt           <= '0;
      decoder_en    <= 1'b0;
      decoder_sel   <= '0;
      grant_valid   <= 1'b0;
      timeout_pulse <= 1'b0;
`ifdef DECODER_RR_SCHED_ONEHOT_EN
      grant_onehot  <= '0;
`endif
    end else begin
      timeout_pulse <= 1'b0;
      unique case (state)
        IDLE, GAP: begin
          cnt <= '0;
          if (arb_go) begin
            state       <= GRANT;
            decoder_sel <= win_idx;
            ptr         <= win_idx + 6'd1;
            decoder_en  <= 1'b1;
            grant_valid <= 1'b1;
`ifdef DECODER_RR_SCHED_ONEHOT_EN
            grant_onehot <= 64'd1 << win_idx;
`endif
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (leave) begin
            state         <= GAP;
            cnt           <= '0;
            decoder_en    <= 1'b0;
            grant_valid   <= 1'b0;
            // Pulse only when the hold limit alone ended the grant.
            timeout_pulse <= timeout & ~other_exit;
`ifdef DECODER_RR_SCHED_ONEHOT_EN
            grant_onehot  <= '0;
`endif
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state      <= IDLE;
          decoder_en <= 1'b0;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_rr_sched.sv
// Self-checking bench for decoder_rr_sched (MAX_HOLD=4).
// Grant order is scored through a queue of expected owner indices.
module tb_decoder_rr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        sched_en;
  logic [63:0] req;
  logic        release_req;
  logic        decoder_en;
  logic [5:0]  decoder_sel;
  logic        grant_valid;
  logic        timeout_pulse;
`ifdef DECODER_RR_SCHED_ONEHOT_EN
  logic [63:0] grant_onehot;
`endif

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];
  logic [5:0] sb_e;
  logic       prev_en = 1'b0;

  decoder_rr_sched #(.MAX_HOLD(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .sched_en     (sched_en),
    .req          (req),
    .release_req  (release_req),
    .decoder_en   (decoder_en),
    .decoder_sel  (decoder_sel),
    .grant_valid  (grant_valid),
    .timeout_pulse(timeout_pulse)
`ifdef DECODER_RR_SCHED_ONEHOT_EN
    ,
    .grant_onehot (grant_onehot)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard: every new grant must match the next queued index.
  always @(negedge clk) begin
    if (decoder_en === 1'b1 && prev_en !== 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_grant: got sel=%0d, none expected", decoder_sel);
      end else begin
        sb_e = exp_q.pop_front();
        if (decoder_sel !== sb_e) begin
          errors++;
          $display("FAIL sb_grant: got sel=%0d, want %0d", decoder_sel, sb_e);
        end
      end
    end
    prev_en = decoder_en;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_grant();
    release_req = 1'b1;
    req = '0;
    step();
    release_req = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sched_en = 1'b0;
    req = '0;
    release_req = 1'b0;
    #1;
    checks++;
    if ({decoder_en, decoder_sel, grant_valid, timeout_pulse} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outs: got %b, want 0",
               {decoder_en, decoder_sel, grant_valid, timeout_pulse});
    end
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    req = 64'h1;
    sched_en = 1'b1;
    exp_q.push_back(6'd0);
    step();
    checks++;
    if (decoder_en !== 1'b1 || decoder_sel !== 6'd0 || grant_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: en=%b sel=%0d gv=%b, want 1 0 1",
               decoder_en, decoder_sel, grant_valid);
    end
    checks++;
    if (dut.ptr !== 6'd1) begin
      errors++;
      $display("FAIL single_ptr: got %0d, want 1", dut.ptr);
    end
    release_req = 1'b1;
    req = '0;
    step();
    checks++;
    if (decoder_en !== 1'b0 || grant_valid !== 1'b0 || timeout_pulse !== 1'b0) begin
      errors++;
      $display("FAIL single_gap: en=%b gv=%b tp=%b, want 0 0 0",
               decoder_en, grant_valid, timeout_pulse);
    end
    release_req = 1'b0;
    step();
  endtask

  task automatic test_rr();
    logic [5:0] order [4];
    order[0] = 6'd3;
    order[1] = 6'd10;
    order[2] = 6'd63;
    order[3] = 6'd3;
    for (int g = 0; g < 4; g++) exp_q.push_back(order[g]);
    req = (64'd1 << 3) | (64'd1 << 10) | (64'd1 << 63);
    step();
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (decoder_en !== 1'b1 || decoder_sel !== order[g]) begin
        errors++;
        $display("FAIL rr_grant%0d: en=%b sel=%0d, want 1 %0d",
                 g, decoder_en, decoder_sel, order[g]);
      end
      release_req = 1'b1;
      if (g == 3) req = '0;
      step();
      checks++;
      if (decoder_en !== 1'b0) begin
        errors++;
        $display("FAIL rr_gap%0d: en=%b, want 0", g, decoder_en);
      end
      release_req = 1'b0;
      step();
    end
    checks++;
    if (decoder_en !== 1'b0) begin
      errors++;
      $display("FAIL rr_idle: en=%b, want 0", decoder_en);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    req = 64'd1 << 5;
    exp_q.push_back(6'd5);
    exp_q.push_back(6'd5);
    step();
    while (decoder_en === 1'b1 && n < 20) begin
      n++;
      checks++;
      if (timeout_pulse !== 1'b0) begin
        errors++;
        $display("FAIL to_early_pulse: tp=%b in grant cycle %0d, want 0",
                 timeout_pulse, n);
      end
      step();
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL to_len: held %0d cycles, want 4", n);
    end
    checks++;
    if (timeout_pulse !== 1'b1 || decoder_en !== 1'b0) begin
      errors++;
      $display("FAIL to_pulse: tp=%b en=%b, want 1 0", timeout_pulse, decoder_en);
    end
    step();
    checks++;
    if (decoder_en !== 1'b1 || decoder_sel !== 6'd5 || timeout_pulse !== 1'b0) begin
      errors++;
      $display("FAIL to_regrant: en=%b sel=%0d tp=%b, want 1 5 0",
               decoder_en, decoder_sel, timeout_pulse);
    end
    finish_grant();
  endtask

  task automatic test_timeout_release();
    req = 64'd1 << 5;
    exp_q.push_back(6'd5);
    exp_q.push_back(6'd5);
    step();
    step();
    step();
    step();
    checks++;
    if (decoder_en !== 1'b1) begin
      errors++;
      $display("FAIL tor_hold: en=%b on 4th cycle, want 1", decoder_en);
    end
    release_req = 1'b1;
    step();
    checks++;
    if (decoder_en !== 1'b0 || timeout_pulse !== 1'b0) begin
      errors++;
      $display("FAIL tor_gap: en=%b tp=%b, want 0 0", decoder_en, timeout_pulse);
    end
    release_req = 1'b0;
    step();
    finish_grant();
  endtask

  task automatic test_sched_drop();
    bit bad = 0;
    req = 64'd1 << 20;
    exp_q.push_back(6'd20);
    step();
    checks++;
    if (decoder_en !== 1'b1 || decoder_sel !== 6'd20) begin
      errors++;
      $display("FAIL sd_grant: en=%b sel=%0d, want 1 20", decoder_en, decoder_sel);
    end
    sched_en = 1'b0;
    req = '1;
    step();
    checks++;
    if (decoder_en !== 1'b0) begin
      errors++;
      $display("FAIL sd_abort: en=%b, want 0", decoder_en);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      if (decoder_en !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL sd_hold_off: en went %b while disabled, want 0", 1'b1);
    end
    sched_en = 1'b1;
    exp_q.push_back(6'd21);
    step();
    checks++;
    if (decoder_en !== 1'b1 || decoder_sel !== 6'd21) begin
      errors++;
      $display("FAIL sd_resume: en=%b sel=%0d, want 1 21", decoder_en, decoder_sel);
    end
    finish_grant();
  endtask

  task automatic test_reset_mid();
    req = 64'd1 << 42;
    exp_q.push_back(6'd42);
    step();
    step();
    checks++;
    if (decoder_en !== 1'b1 || decoder_sel !== 6'd42) begin
      errors++;
      $display("FAIL rm_grant: en=%b sel=%0d, want 1 42", decoder_en, decoder_sel);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (decoder_en !== 1'b0 || decoder_sel !== 6'd0 || grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_async: en=%b sel=%0d gv=%b, want 0 0 0",
               decoder_en, decoder_sel, grant_valid);
    end
`ifdef DECODER_RR_SCHED_ONEHOT_EN
    checks++;
    if (grant_onehot !== 64'd0) begin
      errors++;
      $display("FAIL rm_onehot_rst: got %h, want 0", grant_onehot);
    end
`endif
    req = (64'd1 << 42) | 64'd1;
    step();
    rst = 1'b0;
    exp_q.push_back(6'd0);
    exp_q.push_back(6'd42);
    step();
    checks++;
    if (decoder_en !== 1'b1 || decoder_sel !== 6'd0) begin
      errors++;
      $display("FAIL rm_first: en=%b sel=%0d, want 1 0", decoder_en, decoder_sel);
    end
`ifdef DECODER_RR_SCHED_ONEHOT_EN
    checks++;
    if (grant_onehot !== 64'h1) begin
      errors++;
      $display("FAIL rm_onehot0: got %h, want 1", grant_onehot);
    end
`endif
    release_req = 1'b1;
    step();
    release_req = 1'b0;
    step();
    checks++;
    if (decoder_en !== 1'b1 || decoder_sel !== 6'd42) begin
      errors++;
      $display("FAIL rm_second: en=%b sel=%0d, want 1 42", decoder_en, decoder_sel);
    end
`ifdef DECODER_RR_SCHED_ONEHOT_EN
    checks++;
    if (grant_onehot !== (64'd1 << 42)) begin
      errors++;
      $display("FAIL rm_onehot42: got %h, want %h", grant_onehot, 64'd1 << 42);
    end
`endif
    finish_grant();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_timeout();
    test_timeout_release();
    test_sched_drop();
    test_reset_mid();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d grants never seen, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
